// File: rtl/packet_add_pkg.sv
// packet_add_pkg: shared types and helpers for the packet_add block.
//   state_t    : control FSM states (ACC = accumulating input, OUT = emitting sums)
//   idx_width  : counter/address width for a given accumulator depth
//   clamp_len  : maps LEN=0 or LEN>depth to depth
//   clamp_k    : maps K=0 to 1
package packet_add_pkg;

   localparam int unsigned DEFAULT_DW = 8;
   localparam int unsigned DEFAULT_DD = 64;

   typedef enum logic {
      ACC = 1'b0,
      OUT = 1'b1
   } state_t;

   function automatic int unsigned idx_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int unsigned cfg_width(input int unsigned dw);
      return 2 * dw;
   endfunction

   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
      return (len == 0 || len > depth) ? depth : len;
   endfunction

   function automatic int unsigned clamp_k(input int unsigned k);
      return (k == 0) ? 1 : k;
   endfunction

endpackage

// File: rtl/packet_add_acc_mem.sv
// packet_add_acc_mem: DD x DW register-array accumulator buffer.
//   clk            : clock, write on rising edge
//   we/waddr/wdata : single write port
//   raddr_a/rdata_a: combinational read port (read-modify-write of input beats)
//   raddr_b/rdata_b: combinational read port (output packet)
// Contents are not reset; every location is written on packet 0 before use.
module packet_add_acc_mem #(
   parameter int unsigned DW = 8,
   parameter int unsigned DD = 64,
   parameter int unsigned IW = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [IW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [IW-1:0] raddr_a,
   output logic [DW-1:0] rdata_a,
   input  logic [IW-1:0] raddr_b,
   output logic [DW-1:0] rdata_b
);

   logic [DW-1:0] mem [DD];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/packet_add.sv
// packet_add: AXI-Stream element-wise packet adder.
// Accumulates K input packets of LEN beats into a buffer, then emits one
// LEN-beat packet of the element-wise sums.
//   clk, rst (async, active-low)
//   s_tdata/s_tvalid/s_tlast/s_tready : input stream (s_tlast is not used for counting)
//   m_tdata/m_tvalid/m_tlast/m_tready : output stream
//   config_packet                     : {K, LEN}, latched on the first beat of a group
// Optional macro PACKET_ADD_SATURATE_EN: unsigned saturating accumulation
// instead of modular wrap.
module packet_add
   import packet_add_pkg::*;
#(
   parameter int unsigned DW = DEFAULT_DW,
   parameter int unsigned DD = DEFAULT_DD
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [DW-1:0]   s_tdata,
   input  logic            s_tvalid,
   input  logic            s_tlast,
   output logic            s_tready,
   output logic [DW-1:0]   m_tdata,
   output logic            m_tvalid,
   output logic            m_tlast,
   input  logic            m_tready,
   input  logic [2*DW-1:0] config_packet
);

   localparam int unsigned IW = idx_width(DD);

   state_t        state_q, state_d;
   logic [IW-1:0] i_q, j_q, len_m1_q;
   logic [DW-1:0] p_q, k_m1_q;
   logic          ready_q;

   logic [IW-1:0] cfg_len_m1, len_m1;
   logic [DW-1:0] cfg_k_m1, k_m1;
   logic          first, s_fire, last_in, last_out;
   logic [DW-1:0] rdata_a, rdata_b, acc_sum, wdata;
   logic          unused_tlast;

   assign unused_tlast = s_tlast;

   assign cfg_len_m1 = IW'(clamp_len(32'(config_packet[DW-1:0]), DD) - 1);
   assign cfg_k_m1   = DW'(clamp_k(32'(config_packet[2*DW-1:DW])) - 1);

   // The first beat of a group uses the live config word; later beats use the latched copy.
   assign first  = (i_q == '0) && (p_q == '0);
   assign len_m1 = first ? cfg_len_m1 : len_m1_q;
   assign k_m1   = first ? cfg_k_m1   : k_m1_q;

   assign s_tready = ready_q;
   assign s_fire   = s_tvalid && ready_q;
   assign last_in  = s_fire && (i_q == len_m1) && (p_q == k_m1);
   assign last_out = (state_q == OUT) && m_tready && (j_q == len_m1_q);

`ifdef PACKET_ADD_SATURATE_EN
   logic [DW:0] sum_wide;
   assign sum_wide = {1'b0, rdata_a} + {1'b0, s_tdata};
   assign acc_sum  = sum_wide[DW] ? '1 : sum_wide[DW-1:0];
`else
   assign acc_sum = rdata_a + s_tdata;
`endif

   assign wdata = (p_q == '0) ? s_tdata : acc_sum;

   packet_add_acc_mem #(
      .DW (DW),
      .DD (DD),
      .IW (IW)
   ) u_mem (
      .clk     (clk),
      .we      (s_fire),
      .waddr   (i_q),
      .wdata   (wdata),
      .raddr_a (i_q),
      .rdata_a (rdata_a),
      .raddr_b (j_q),
      .rdata_b (rdata_b)
   );

   // The final sum is written on the last input edge and read combinationally
   // in OUT, so LEN=1 sees the completed value without a bypass path.
   assign m_tdata = (state_q == OUT) ? rdata_b : '0;

   always_comb begin
      state_d  = state_q;
      m_tvalid = 1'b0;
      m_tlast  = 1'b0;
      unique case (state_q)
         ACC: if (last_in) state_d = OUT;
         OUT: begin
            m_tvalid = 1'b1;
            m_tlast  = (j_q == len_m1_q);
            if (last_out) state_d = ACC;
         end
         default: state_d = ACC;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ACC;
         ready_q  <= 1'b0;
         i_q      <= '0;
         j_q      <= '0;
         p_q      <= '0;
         len_m1_q <= '0;
         k_m1_q   <= '0;
      end else begin
         state_q <= state_d;
         ready_q <= (state_d == ACC);
         if (s_fire) begin
            if (first) begin
               len_m1_q <= cfg_len_m1;
               k_m1_q   <= cfg_k_m1;
            end
            if (i_q == len_m1) begin
               i_q <= '0;
               p_q <= (p_q == k_m1) ? '0 : p_q + 1'b1;
            end else begin
               i_q <= i_q + 1'b1;
            end
         end
         if ((state_q == OUT) && m_tready) begin
            j_q <= last_out ? '0 : j_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_packet_add.sv
module tb_packet_add;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  s_tdata;
   logic        s_tvalid;
   logic        s_tlast;
   logic        s_tready;
   logic [7:0]  m_tdata;
   logic        m_tvalid;
   logic        m_tlast;
   logic        m_tready = 1'b1;
   logic [15:0] config_packet;

   int checks = 0;
   int errors = 0;
   bit bp = 1'b0;

   logic [8:0] exp_q[$];      // {last, data}
   logic [7:0] din   [512];
   logic [7:0] exp_d [256];
   int         waits [512];

   logic       prev_stall = 1'b0;
   logic [7:0] prev_data  = '0;
   logic       prev_last  = 1'b0;

`ifdef PACKET_ADD_SATURATE_EN
   localparam logic [7:0] OVF_EXP = 8'd255;
`else
   localparam logic [7:0] OVF_EXP = 8'd44;
`endif

   packet_add #(.DW(8), .DD(64)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_tdata       (s_tdata),
      .s_tvalid      (s_tvalid),
      .s_tlast       (s_tlast),
      .s_tready      (s_tready),
      .m_tdata       (m_tdata),
      .m_tvalid      (m_tvalid),
      .m_tlast       (m_tlast),
      .m_tready      (m_tready),
      .config_packet (config_packet)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Monitor: m_tready is set first, then the handshake that the next
   // rising edge will perform is evaluated against the scoreboard.
   always @(negedge clk) begin
      m_tready = bp ? ~m_tready : 1'b1;
      if (!rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (!m_tvalid || m_tdata !== prev_data || m_tlast !== prev_last) begin
               errors++;
               $display("FAIL hold: got valid=%0b data=%0d last=%0b, required valid=1 data=%0d last=%0b",
                        m_tvalid, m_tdata, m_tlast, prev_data, prev_last);
            end
         end
         if (m_tvalid && m_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat: got data=%0d last=%0b, required no beat", m_tdata, m_tlast);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               if ({m_tlast, m_tdata} !== e) begin
                  errors++;
                  $display("FAIL out_beat: got data=%0d last=%0b, required data=%0d last=%0b",
                           m_tdata, m_tlast, e[7:0], e[8]);
               end
            end
         end
         prev_stall = m_tvalid && !m_tready;
         prev_data  = m_tdata;
         prev_last  = m_tlast;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the transfer.
   task automatic send_beat(input logic [7:0] d, input logic last, output int waited);
      s_tdata  = d;
      s_tlast  = last;
      s_tvalid = 1'b1;
      waited   = 0;
      while (!s_tready && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      if (!s_tready) begin
         checks++;
         errors++;
         $display("FAIL s_tready_timeout: got s_tready=0 after %0d cycles, required 1", waited);
      end
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic send_range(input int lo, input int hi, input int len);
      for (int i = lo; i < hi; i++) send_beat(din[i], (i % len) == len - 1, waits[i]);
   endtask

   task automatic push_exp(input int len, input int n);
      for (int j = 0; j < n; j++) exp_q.push_back({((j % len) == len - 1), exp_d[j]});
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(negedge clk);
      chk({name, "_idle_tvalid"}, 32'(m_tvalid), 0);
      chk({name, "_idle_tready"}, 32'(s_tready), 1);
   endtask

   initial begin
      rst = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; config_packet = '0;
      repeat (3) @(negedge clk);
      chk("reset_s_tready", 32'(s_tready), 0);
      chk("reset_m_tvalid", 32'(m_tvalid), 0);
      chk("reset_m_tlast",  32'(m_tlast),  0);
      chk("reset_m_tdata",  32'(m_tdata),  0);
      rst = 1'b1;
      @(negedge clk);
      chk("release_s_tready", 32'(s_tready), 1);

      // K=2 LEN=64: i + 2i = 3i mod 256, one-cycle output latency
      config_packet = {8'd2, 8'd64};
      for (int i = 0; i < 64; i++) begin
         din[i] = 8'(i); din[64 + i] = 8'(2 * i); exp_d[i] = 8'((3 * i) % 256);
      end
      push_exp(64, 64);
      send_range(0, 127, 64);
      chk("pre_last_m_tvalid", 32'(m_tvalid), 0);
      send_beat(din[127], 1'b1, waits[127]);
      chk("latency_m_tvalid", 32'(m_tvalid), 1);
      chk("latency_m_tdata",  32'(m_tdata),  0);
      wait_drain("t1");

      // Two back-to-back groups; input stalls exactly for the 64 output beats
      for (int i = 0; i < 64; i++) begin
         din[i] = 8'(i); din[64 + i] = 8'(i + 10); din[128 + i] = 8'(i); din[192 + i] = 8'd3;
         exp_d[i] = 8'(2 * i + 10); exp_d[64 + i] = 8'(i + 3);
      end
      push_exp(64, 128);
      send_range(0, 256, 64);
      chk("no_gap_in_group", 32'(waits[64]), 0);
      chk("stall_between_groups", 32'(waits[128]), 64);
      wait_drain("t2");

      // Backpressure: m_tready toggles every cycle
      bp = 1'b1;
      for (int i = 0; i < 64; i++) begin
         din[i] = 8'(i); din[64 + i] = 8'd100; exp_d[i] = 8'(i + 100);
      end
      push_exp(64, 64);
      send_range(0, 128, 64);
      wait_drain("t3");
      bp = 1'b0;

      // Overflow with LEN=1
      config_packet = {8'd2, 8'd1};
      din[0] = 8'd200; din[1] = 8'd100; exp_d[0] = OVF_EXP;
      push_exp(1, 1);
      send_range(0, 2, 1);
      wait_drain("t4");

      // K=1 pass-through
      config_packet = {8'd1, 8'd4};
      for (int i = 0; i < 4; i++) begin din[i] = 8'(5 + i); exp_d[i] = 8'(5 + i); end
      push_exp(4, 4);
      send_range(0, 4, 4);
      wait_drain("t5");

      // LEN=0 -> 64 beats
      config_packet = {8'd1, 8'd0};
      for (int i = 0; i < 64; i++) begin din[i] = 8'(255 - i); exp_d[i] = 8'(255 - i); end
      push_exp(64, 64);
      send_range(0, 64, 64);
      wait_drain("t6");

      // K=0 -> one packet
      config_packet = {8'd0, 8'd2};
      din[0] = 8'd9; din[1] = 8'd10; exp_d[0] = 8'd9; exp_d[1] = 8'd10;
      push_exp(2, 2);
      send_range(0, 2, 2);
      wait_drain("t7");

      // LEN>DD -> 64 beats
      config_packet = {8'd1, 8'd200};
      for (int i = 0; i < 64; i++) begin din[i] = 8'(i) ^ 8'h5A; exp_d[i] = 8'(i) ^ 8'h5A; end
      push_exp(64, 64);
      send_range(0, 64, 64);
      wait_drain("t8");

      // Reset after 30 beats of a group, then a fresh group
      config_packet = {8'd2, 8'd64};
      for (int i = 0; i < 64; i++) din[i] = 8'd77;
      send_range(0, 30, 64);
      rst = 1'b0;
      #1;
      chk("midreset_s_tready", 32'(s_tready), 0);
      chk("midreset_m_tvalid", 32'(m_tvalid), 0);
      chk("midreset_m_tlast",  32'(m_tlast),  0);
      chk("midreset_m_tdata",  32'(m_tdata),  0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 64; i++) begin
         din[i] = 8'(2 * i); din[64 + i] = 8'd1; exp_d[i] = 8'(2 * i + 1);
      end
      push_exp(64, 64);
      send_range(0, 128, 64);
      wait_drain("t9");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/packet_add.md
Name: packet_add

Overview:
- AXI-Stream element-wise packet adder.
- Accepts K consecutive input packets of LEN beats each and accumulates them element by element in an internal buffer of depth DD.
- Then emits one LEN-beat output packet holding the element-wise sums.
- Sits between a stream source and sink; K and LEN come from a static configuration word.

Parameters:
DW, 8, data width of stream beats and of each config field
DD, 64, accumulator depth (maximum LEN)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
s_tdata  in  DW  input beat data
s_tvalid  in  1  input beat valid
s_tlast  in  1  input end-of-packet marker (informational, see Behaviour)
s_tready  out  1  block can accept an input beat
m_tdata  out  DW  output sum element
m_tvalid  out  1  output beat valid
m_tlast  out  1  last beat of output packet
m_tready  in  1  sink accepts output beat
config_packet  in  2*DW  {K[2*DW-1:DW], LEN[DW-1:0]}

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-low.
- Reset values: state=ACC, s_tready=0 during reset and 1 the first cycle after; m_tvalid=0; m_tlast=0; m_tdata=0; all counters=0. Buffer contents need not be reset.
- Config latch: K and LEN are captured into internal registers on the first accepted beat of each group (beat 0, packet 0). They are held until the group's output packet completes.
  - K=0 is treated as 1.
  - LEN=0 or LEN>DD is treated as DD.
- Handshake: a beat transfers when valid && ready. Valid is never dropped once raised until accepted. m_tdata/m_tlast stay stable while m_tvalid && !m_tready.
- State ACC: s_tready=1, m_tvalid=0.
  - Beat index i (0..LEN-1) and packet count p (0..K-1).
  - p=0: buf[i] <= s_tdata. p>0: buf[i] <= buf[i] + s_tdata, truncated to DW bits (mod 2^DW).
  - i wraps at LEN-1 and p increments.
  - On the accepted beat with i=LEN-1, p=K-1, transition to OUT.
- Packet boundaries are defined by LEN only; s_tlast does not affect counting.
- State OUT: s_tready=0.
  - m_tvalid=1 starting the cycle after the final input beat (latency 1 clk), with m_tdata=buf[0].
  - Read index j advances on each m_tready handshake. m_tlast=1 when j=LEN-1.
  - On the handshake of the last beat, return to ACC (s_tready=1 the next cycle; p, i, j cleared).
- Final input beat: its sum is written to buf before it is read, so LEN=1 must output the correct sum (bypass or write-first required).
- K=1: output equals the input packet (pass-through with 1-packet store).
- Input is not accepted while outputting; there is no overlap between groups.
- Reset mid-operation (either state): immediately abort, return to reset values, discard partial sums.

Optional Feature:
PACKET_ADD_SATURATE_EN
- Defined: accumulation saturates at 2^DW-1, unsigned (200+100 -> 255).
- Undefined: modular wrap (200+100 -> 44).

Decomposition:
- Package packet_add_pkg: state enum typedef (ACC, OUT), helper function for clamp of LEN/K, width constants derived from DW.
- One natural sub-module: packet_add_acc_mem, a DD x DW register-array buffer with one write port, one combinational read port for read-modify-write, and one output read port.
- Control FSM and counters stay in the top level.

Test Plan:
- K=2, LEN=64: packet A beats i (0..63), packet B beats 2i -> output 64 beats of 3i mod 256, m_tlast only on beat 63, m_tvalid rises 1 clk after B's last beat.
- K=2, LEN=64, four packets (256 beats) -> two output packets; s_tready=0 for exactly the 64 output cycles between groups.
- Backpressure: m_tready toggled 1/0 every cycle during output -> m_tdata held while stalled; all 64 values correct, no duplicates.
- Overflow: K=2, LEN=1, beats 200 then 100 -> output 44 (macro off) / 255 (PACKET_ADD_SATURATE_EN on); m_tlast=1.
- K=1, LEN=4, data 5,6,7,8 -> output 5,6,7,8; LEN=0 config -> 64-beat packets.
- Assert rst=0 after 30 input beats, release, send fresh K=2 LEN=64 group -> output reflects only post-reset data; outputs 0 during reset.
